// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: memory fetch channel, redirect inputs and decoder-facing queue head.
// master = fetch unit, slave = memory/decoder/back-end side.
interface ifetch_queue_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INST_WIDTH  = 32,
  parameter int unsigned QUEUE_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rdy;
  logic [INST_WIDTH-1:0] inst_in;

  logic                  flush;
  logic [ADDR_WIDTH-1:0] rob2if;
  logic                  alu2if_cont;
  logic [ADDR_WIDTH-1:0] alu2if;
  logic                  dec2if_upd;
  logic [ADDR_WIDTH-1:0] dec2if;
  logic                  dec2if_en;

  logic                  if2dec;
  logic [INST_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [CNT_W-1:0]      queue_cnt;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdy, inst_in,
    input  flush, rob2if, alu2if_cont, alu2if, dec2if_upd, dec2if, dec2if_en,
    output if2dec, inst_out, pc_out, queue_cnt
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdy, inst_in,
    output flush, rob2if, alu2if_cont, alu2if, dec2if_upd, dec2if, dec2if_en,
    input  if2dec, inst_out, pc_out, queue_cnt
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single outstanding request, {pc, inst} FIFO towards the decoder,
// optional stall after control-flow instructions, flush/redirect handling with stale-response drain.
module ifetch_queue #(
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          INST_WIDTH      = 32,
  parameter int unsigned          QUEUE_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter bit                   STALL_ON_BRANCH = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  ifetch_queue_if.master bus
);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FETCH, WAIT_BR, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  enq, deq;

  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [QUEUE_DEPTH];

  // State register; rdy_in=0 leaves every *_d equal to its *_q
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= FETCH;
      fpc_q      <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state: flush dominates; redirects only matter while stalled on a branch
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    enq        = 1'b0;
    deq        = 1'b0;

    if (rdy_in) begin
      if (bus.flush) begin
        fpc_d     = bus.rob2if;
        rd_ptr_d  = '0;
        wr_ptr_d  = '0;
        cnt_d     = '0;
        mem_req_d = 1'b0;
        if (state_q == DRAIN)
          state_d = bus.mem_rdy ? FETCH : DRAIN;
        else if (mem_req_q && !bus.mem_rdy)
          state_d = DRAIN;
        else
          state_d = FETCH;
      end else begin
        deq = (cnt_q != '0) && bus.dec2if_en;
        case (state_q)
          FETCH: begin
            if (mem_req_q && bus.mem_rdy) begin
              enq       = 1'b1;
              fpc_d     = fpc_q + ADDR_WIDTH'(4);
              mem_req_d = 1'b0;
              if (STALL_ON_BRANCH && (bus.inst_in[6:4] == 3'b110))
                state_d = WAIT_BR;
            end else if (!mem_req_q && (cnt_q < CNT_W'(QUEUE_DEPTH))) begin
              mem_req_d  = 1'b1;
              mem_addr_d = fpc_q;
            end
          end
          WAIT_BR: begin
            if (bus.alu2if_cont) begin
              fpc_d   = bus.alu2if;
              state_d = FETCH;
            end else if (bus.dec2if_upd) begin
              fpc_d   = bus.dec2if;
              state_d = FETCH;
            end
          end
          DRAIN: begin
            if (bus.mem_rdy)
              state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
        if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible through cnt_q
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= fpc_q;
      inst_mem[wr_ptr_q] <= bus.inst_in;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.queue_cnt = cnt_q;
  assign bus.if2dec    = (cnt_q != '0);
  assign bus.inst_out  = (cnt_q != '0) ? inst_mem[rd_ptr_q] : '0;
  assign bus.pc_out    = (cnt_q != '0) ? pc_mem[rd_ptr_q]   : '0;
endmodule
